scanner_source_sequencer: RTL

Initiator side of the light-source handshake, sitting between the scanner main FSM and the source/environment controller. On a scan request it waits for `env_ok`, drives `cmd_source_active`, confirms `source_on`, holds a stabilisation delay, then presents `source_ready` to the main FSM. On release it switches the source off and confirms `source_on` has dropped. Every wait is bounded by a timeout; failures latch sticky error flags until cleared.

---
 rtl/scanner_source_sequencer_pkg.sv | 29 ++
 rtl/scanner_phase_timer.sv | 23 ++
 rtl/scanner_source_sequencer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/scanner_source_sequencer_pkg.sv
// Shared encodings and payload types for the scanner light-source sequencer.
package scanner_source_sequencer_pkg;

    localparam logic [2:0] SEQ_IDLE         = 3'd0;
    localparam logic [2:0] SEQ_WAIT_ENV     = 3'd1;
    localparam logic [2:0] SEQ_SRC_ON_WAIT  = 3'd2;
    localparam logic [2:0] SEQ_STABILIZE    = 3'd3;
    localparam logic [2:0] SEQ_READY        = 3'd4;
    localparam logic [2:0] SEQ_SRC_OFF_WAIT = 3'd5;
    localparam logic [2:0] SEQ_ERROR        = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE         = SEQ_IDLE,
        ST_WAIT_ENV     = SEQ_WAIT_ENV,
        ST_SRC_ON_WAIT  = SEQ_SRC_ON_WAIT,
        ST_STABILIZE    = SEQ_STABILIZE,
        ST_READY        = SEQ_READY,
        ST_SRC_OFF_WAIT = SEQ_SRC_OFF_WAIT,
        ST_ERROR        = SEQ_ERROR
    } seq_state_e;

    typedef struct packed {
        logic env_timeout;
        logic on_timeout;
        logic off_timeout;
        logic source_lost;
    } err_flags_t;

endpackage

// File: rtl/scanner_phase_timer.sv
// Per-state phase counter; terminal flags the last permitted cycle of a phase.
module scanner_phase_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [CNT_W:0]   limit,
    output logic             terminal
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)      cnt <= '0;
        else if (clear) cnt <= '0;
        else            cnt <= cnt + CNT_W'(1);
    end

    // limit is one bit wider so a limit of 2^CNT_W is representable
    assign terminal = ({1'b0, cnt} == (limit - (CNT_W + 1)'(1)));

endmodule

// File: rtl/scanner_source_sequencer.sv
// Initiator side of the light-source handshake: env check, source on, stabilise, ready, release.
module scanner_source_sequencer
    import scanner_source_sequencer_pkg::*;
#(
    parameter int unsigned ENV_TIMEOUT   = 32,
    parameter int unsigned ON_TIMEOUT    = 4,
    parameter int unsigned STABLE_CYCLES = 3,
    parameter int unsigned OFF_TIMEOUT   = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scan_req,
    input  logic       scan_abort,
    input  logic       err_clear,
    input  logic       env_ok,
    input  logic       source_on,
    output logic       cmd_source_active,
    output logic       source_ready,
    output logic       busy,
    output logic       err_env_timeout,
    output logic       err_on_timeout,
    output logic       err_off_timeout,
    output logic       err_source_lost,
    output logic [2:0] state_o
);

    localparam int unsigned LIM_W = CNT_W + 1;

    seq_state_e       state_q, state_d;
    err_flags_t       flags_q, flags_d;
    logic             rel;
    logic             terminal;
    logic [LIM_W-1:0] limit;

    assign rel = !scan_req || scan_abort;

    always_comb begin
        limit = LIM_W'(1);
        case (state_q)
            ST_WAIT_ENV:     limit = LIM_W'(ENV_TIMEOUT);
            ST_SRC_ON_WAIT:  limit = LIM_W'(ON_TIMEOUT);
            ST_STABILIZE:    limit = LIM_W'(STABLE_CYCLES);
            ST_SRC_OFF_WAIT: limit = LIM_W'(OFF_TIMEOUT);
            default:         limit = LIM_W'(1);
        endcase
    end

    scanner_phase_timer #(.CNT_W(CNT_W)) u_phase_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (state_d != state_q),
        .limit    (limit),
        .terminal (terminal)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
        end
    end

    // Next state and flag updates; within a state the first matching condition wins
    always_comb begin
        state_d = state_q;
        flags_d = flags_q;
        case (state_q)
            ST_IDLE: begin
                if (scan_req) state_d = ST_WAIT_ENV;
            end
            ST_WAIT_ENV: begin
                if (rel)           state_d = ST_IDLE;
                else if (env_ok)   state_d = ST_SRC_ON_WAIT;
                else if (terminal) begin
                    state_d             = ST_ERROR;
                    flags_d.env_timeout = 1'b1;
                end
            end
            ST_SRC_ON_WAIT: begin
                if (rel)            state_d = ST_SRC_OFF_WAIT;
                else if (source_on) state_d = ST_STABILIZE;
                else if (terminal) begin
                    state_d            = ST_ERROR;
                    flags_d.on_timeout = 1'b1;
                end
            end
            ST_STABILIZE: begin
                if (!source_on) begin
                    state_d             = ST_ERROR;
                    flags_d.source_lost = 1'b1;
                end
                else if (rel)      state_d = ST_SRC_OFF_WAIT;
                else if (terminal) state_d = ST_READY;
            end
            ST_READY: begin
                if (!source_on) begin
                    state_d             = ST_ERROR;
                    flags_d.source_lost = 1'b1;
                end
                else if (rel) state_d = ST_SRC_OFF_WAIT;
            end
            ST_SRC_OFF_WAIT: begin
                if (!source_on) state_d = ST_IDLE;
                else if (terminal) begin
                    state_d             = ST_ERROR;
                    flags_d.off_timeout = 1'b1;
                end
            end
            ST_ERROR: begin
                if (err_clear) begin
                    state_d = ST_IDLE;
                    flags_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs registered from the next state so they track state_q exactly
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_source_active <= 1'b0;
            source_ready      <= 1'b0;
            busy              <= 1'b0;
            state_o           <= SEQ_IDLE;
        end else begin
            cmd_source_active <= (state_d == ST_SRC_ON_WAIT) || (state_d == ST_STABILIZE) ||
                                 (state_d == ST_READY);
            source_ready      <= (state_d == ST_READY);
            busy              <= (state_d != ST_IDLE);
            state_o           <= state_d;
        end
    end

    assign err_env_timeout = flags_q.env_timeout;
    assign err_on_timeout  = flags_q.on_timeout;
    assign err_off_timeout = flags_q.off_timeout;
    assign err_source_lost = flags_q.source_lost;

endmodule
